// File: rtl/viterbi_tx_rx.sv
// viterbi_tx_rx
//   Loopback link: rate-1/2 K=3 convolutional encoder (generators 7,5 octal),
//   a deterministic channel that inverts c0 once every ERR_PERIOD enabled
//   cycles, and a 4-state hard-decision register-exchange Viterbi decoder.
//   The decoded stream is delayed so that a bit sampled at enabled edge n
//   appears on decoder_o right after enabled edge n+LATENCY.
// Ports
//   clk               clock, rising-edge
//   rst               synchronous active-high reset (wins over enable)
//   encoder_i         data bit, sampled on each enabled edge
//   enable_encoder_i  advance enable for the whole chain
//   decoder_o         decoded data bit (registered)
module viterbi_tx_rx #(
  parameter int TB_DEPTH   = 32,
  parameter int LATENCY    = 4104,
  parameter int ERR_PERIOD = 100,
  parameter int PM_W       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic encoder_i,
  input  logic enable_encoder_i,
  output logic decoder_o
);

  // Decision for bit n is available after edge n+TB_DEPTH; the delay line
  // supplies the remainder of the latency.
  localparam int DL_LEN = LATENCY - TB_DEPTH;
  localparam int CNT_W  = (ERR_PERIOD > 1) ? $clog2(ERR_PERIOD) : 1;
  localparam logic [PM_W-1:0] PM_INIT = {2'b01, {(PM_W-2){1'b0}}};

  logic [1:0]                 enc_s_q, enc_s_d;
  logic [1:0]                 sym_q, sym_d;      // {c0, c1}
  logic [CNT_W-1:0]           err_cnt_q, err_cnt_d;
  logic [3:0][PM_W-1:0]       pm_q, pm_d;
  logic [3:0][TB_DEPTH-1:0]   path_q, path_d;
  logic [DL_LEN-1:0]          dl_q, dl_d;

  logic                       flip;
  logic [1:0]                 r;
  logic [3:0][PM_W-1:0]       acs_pm;
  logic                       dec_bit;

  function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] d;
    d = a ^ b;
    return {1'b0, d[1]} + {1'b0, d[0]};
  endfunction

  // Encoder
  always_comb begin
    sym_d   = {encoder_i ^ enc_s_q[1] ^ enc_s_q[0], encoder_i ^ enc_s_q[0]};
    enc_s_d = {encoder_i, enc_s_q[1]};
  end

  // Channel error injection
  generate
    if (ERR_PERIOD == 0) begin : g_no_err
      assign flip      = 1'b0;
      assign err_cnt_d = err_cnt_q;
    end else begin : g_err
      assign flip      = (err_cnt_q == CNT_W'(ERR_PERIOD - 1));
      assign err_cnt_d = flip ? '0 : err_cnt_q + 1'b1;
    end
  endgenerate

  assign r = {sym_q[1] ^ flip, sym_q[0]};

  // Add-compare-select: next state ns = {u, s1}, predecessors {s1,0} / {s1,1}
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_acs
      localparam int U  = gi / 2;
      localparam int S1 = gi % 2;
      localparam int P0 = 2 * S1;
      localparam int P1 = 2 * S1 + 1;
      localparam logic [1:0] E0 = 2'(((U ^ S1) << 1) | U);
      localparam logic [1:0] E1 = 2'(((U ^ S1 ^ 1) << 1) | (U ^ 1));
      logic [PM_W-1:0]     sum0, sum1;
      logic                sel1;
      logic [TB_DEPTH-1:0] win_path;
      assign sum0     = pm_q[P0] + PM_W'(hamming2(r, E0));
      assign sum1     = pm_q[P1] + PM_W'(hamming2(r, E1));
      assign sel1     = (sum1 < sum0);   // tie keeps the s0=0 predecessor
      assign acs_pm[gi] = sel1 ? sum1 : sum0;
      assign win_path = sel1 ? path_q[P1] : path_q[P0];
      assign path_d[gi] = {win_path[TB_DEPTH-2:0], 1'(U)};
    end
  endgenerate

  // Normalize so the best metric is always zero
  always_comb begin
    logic [PM_W-1:0] min_pm;
    min_pm = acs_pm[0];
    for (int i = 1; i < 4; i++) begin
      if (acs_pm[i] < min_pm) min_pm = acs_pm[i];
    end
    pm_d = '0;
    for (int i = 0; i < 4; i++) begin
      pm_d[i] = acs_pm[i] - min_pm;
    end
  end

  // Decision from the current best state; descending scan with <= keeps the
  // lowest index on ties
  always_comb begin
    logic [1:0] best;
    best = 2'd3;
    for (int i = 2; i >= 0; i--) begin
      if (pm_q[i] <= pm_q[best]) best = 2'(i);
    end
    dec_bit = path_q[best][TB_DEPTH-1];
  end

  assign dl_d      = {dl_q[DL_LEN-2:0], dec_bit};
  assign decoder_o = dl_q[DL_LEN-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      enc_s_q   <= '0;
      sym_q     <= '0;
      err_cnt_q <= '0;
      pm_q      <= {PM_INIT, PM_INIT, PM_INIT, {PM_W{1'b0}}};
      path_q    <= '0;
      dl_q      <= '0;
    end else if (enable_encoder_i) begin
      enc_s_q   <= enc_s_d;
      sym_q     <= sym_d;
      err_cnt_q <= err_cnt_d;
      pm_q      <= pm_d;
      path_q    <= path_d;
      dl_q      <= dl_d;
    end
  end

endmodule

// File: tb/tb_viterbi_tx_rx.sv
module tb_viterbi_tx_rx;

  localparam int LAT = 4104;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic encoder_i = 1'b0;
  logic enable_encoder_i = 1'b0;
  logic decoder_o;

  viterbi_tx_rx #(
    .TB_DEPTH(32), .LATENCY(LAT), .ERR_PERIOD(100), .PM_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .encoder_i(encoder_i),
    .enable_encoder_i(enable_encoder_i),
    .decoder_o(decoder_o)
  );

  always #5 clk = ~clk;

  // Reference: the link is an ideal delay of LAT enabled edges, zero before
  // the first real bit, restarted by reset, frozen while disabled.
  bit exp_q[$];
  bit hist[$];
  bit last_exp = 1'b0;
  int tests = 0;
  int fails = 0;
  int cycle = 0;

  task automatic step(input logic r, input logic e, input logic u);
    int n;
    @(negedge clk);
    rst = r;
    enable_encoder_i = e;
    encoder_i = u;
    @(posedge clk);
    if (r) begin
      hist.delete();
      last_exp = 1'b0;
    end else if (e) begin
      hist.push_back(u);
      n = hist.size() - 1;
      last_exp = (n >= LAT) ? hist[n - LAT] : 1'b0;
    end
    exp_q.push_back(last_exp);
  endtask

  // Monitor: one expected value per clock edge
  always @(posedge clk) begin
    bit e;
    #1;
    cycle++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (decoder_o !== e) begin
        fails++;
        if (fails <= 20)
          $display("FAIL decoder_o cycle %0d: got %b expected %b", cycle, decoder_o, e);
      end
    end
  end

  initial begin
    logic [28:0] pat;
    pat = 29'b10011000111000011110000011111;

    // All-zero input with periodic channel flips
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 1'b0);

    // Fixed pattern, repeated
    step(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++)
      for (int i = 28; i >= 0; i--) step(1'b0, 1'b1, pat[i]);

    // Constant 1 with isolated 0 pulses every 101 cycles
    for (int p = 0; p < 40; p++) begin
      for (int k = 0; k < 100; k++) step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b0);
    end

    // Random data with a 7-cycle stall in the middle
    for (int i = 0; i < 250; i++) step(1'b0, 1'b1, 1'($urandom_range(1)));
    for (int i = 0; i < 7; i++)   step(1'b0, 1'b0, 1'($urandom_range(1)));
    for (int i = 0; i < 250 + LAT; i++) step(1'b0, 1'b1, 1'($urandom_range(1)));

    // Mid-stream reset, then a fresh random stream fully drained
    step(1'b1, 1'b1, 1'($urandom_range(1)));
    for (int i = 0; i < 400 + LAT; i++) step(1'b0, 1'b1, 1'($urandom_range(1)));

    repeat (3) @(posedge clk);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
